// File: rtl/fracturable_slicel_if.sv
// Port bundle for one fracturable logic slice: config shift/commit chain,
// LUT inputs and outputs, flop controls and the carry chain.
interface fracturable_slicel_if #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4
);
    logic                              cen;
    logic                              shift_in;
    logic                              shift_out;
    logic                              set_in;
    logic                              set_out;
    logic [2*S_XX_BASE*NUM_LUTS-1:0]   luts_input;
    logic                              reg_we;
    logic                              reg_init;
    logic [2*NUM_LUTS-1:0]             lut_output;
    logic [2*NUM_LUTS-1:0]             lut_output_registered;
    logic                              carry_in;
    logic                              carry_out;

    modport master (
        output cen, shift_in, set_in, luts_input, reg_we, reg_init, carry_in,
        input  shift_out, set_out, lut_output, lut_output_registered, carry_out
    );

    modport slave (
        input  cen, shift_in, set_in, luts_input, reg_we, reg_init, carry_in,
        output shift_out, set_out, lut_output, lut_output_registered, carry_out
    );
endinterface

// File: rtl/fracturable_slicel.sv
// Logic slice: NUM_LUTS fracturable LUTs, ripple carry chain and 2*NUM_LUTS
// output flops, configured through a double-buffered (shadow/active) shift chain.
module fracturable_slicel #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4
) (
    input logic                 clk,
    input logic                 rst,
    fracturable_slicel_if.slave bus
);
    localparam int TBL_BITS  = 2 ** (S_XX_BASE + 1);
    localparam int LUT_CFG   = TBL_BITS + 1;
    localparam int NUM_OUT   = 2 * NUM_LUTS;
    localparam int INIT_BASE = NUM_LUTS * LUT_CFG;
    localparam int CFG_BITS  = INIT_BASE + NUM_OUT + 1;

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic                set_q;
    logic [NUM_OUT-1:0]  regs;
    logic [NUM_OUT-1:0]  lut_out;
    logic [NUM_LUTS-1:0] o0;
    logic [NUM_LUTS-1:0] a0;
    logic [NUM_LUTS-1:0] sum;
    logic                chain_out;
    logic                carry_en;

    assign carry_en = active[CFG_BITS-1];

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // that is what lets a commit capture the shadow before a same-cycle shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
            set_q  <= 1'b0;
            regs   <= '0;
        end else begin
            set_q <= bus.set_in;
            if (bus.cen) begin
                shadow <= {bus.shift_in, shadow[CFG_BITS-1:1]};
            end
            if (bus.set_in) begin
                active <= shadow;
            end
            // Commit reloads init bits straight from the incoming shadow.
            if (bus.set_in) begin
                regs <= shadow[INIT_BASE +: NUM_OUT];
            end else if (bus.reg_init) begin
                regs <= active[INIT_BASE +: NUM_OUT];
            end else if (bus.reg_we) begin
                regs <= lut_out;
            end
        end
    end

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic [S_XX_BASE-1:0] a;
        logic [S_XX_BASE-1:0] b;
        logic [TBL_BITS-1:0]  tbl;
        logic                 frac;
        logic                 o1;

        assign a    = bus.luts_input[2*S_XX_BASE*i +: S_XX_BASE];
        assign b    = bus.luts_input[2*S_XX_BASE*i + S_XX_BASE +: S_XX_BASE];
        assign tbl  = active[i*LUT_CFG +: TBL_BITS];
        assign frac = active[i*LUT_CFG + TBL_BITS];

        // Split mode uses the two table halves; fused mode one full-depth LUT.
        assign o0[i] = frac ? tbl[{1'b0, a}] : tbl[{b[0], a}];
        assign o1    = frac ? tbl[{1'b1, b}] : o0[i];
        assign a0[i] = a[0];

        assign lut_out[2*i]   = o0[i];
        assign lut_out[2*i+1] = carry_en ? sum[i] : o1;
    end

    // NOTE: the ripple is built with a block-local variable assigned before
    // use on every path, so the chain stays purely combinational (no latch).
    always_comb begin
        logic c;
        c   = bus.carry_in;
        sum = '0;
        for (int i = 0; i < NUM_LUTS; i++) begin
            sum[i] = o0[i] ^ c;
            c      = o0[i] ? c : a0[i];
        end
        chain_out = c;
    end

    assign bus.shift_out             = shadow[0];
    assign bus.set_out               = set_q;
    assign bus.lut_output            = lut_out;
    assign bus.lut_output_registered = regs;
    assign bus.carry_out             = carry_en ? chain_out : bus.carry_in;
endmodule

// File: doc/fracturable_slicel.md
# fracturable_slicel

Parametrised successor to the fabric's baked logic slice. It holds NUM_LUTS fracturable LUTs, a ripple carry chain, and 2*NUM_LUTS output flops with configurable init values. Unlike the previous slice, configuration is double-buffered: a shadow shift chain loads serially while the active configuration keeps driving logic, and a commit pulse swaps it in atomically. It sits in a CLB tile and is daisy-chained with the other slices on the tile's config shift and commit chains.

## Interface
- S_XX_BASE, 4: inputs per LUT half; each LUT holds a 2^(S_XX_BASE+1)-bit table
- NUM_LUTS, 4: fracturable LUTs per slice
- LUT_CFG (derived), 2^(S_XX_BASE+1)+1: per-LUT config bits (table + frac bit)
- CFG_BITS (derived), NUM_LUTS*LUT_CFG + 2*NUM_LUTS + 1: config chain length (141 at defaults)

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- cen  in  1  config shift enable
- shift_in  in  1  serial config data
- shift_out  out  1  = shadow[0]; feeds the next slice's shift_in
- set_in  in  1  config commit pulse
- set_out  out  1  set_in delayed one cycle; feeds the next slice
- luts_input  in  2*S_XX_BASE*NUM_LUTS  per-LUT inputs
- reg_we  in  1  output flop write enable
- reg_init  in  1  reload flops with their init values
- lut_output  out  2*NUM_LUTS  combinational LUT/carry outputs
- lut_output_registered  out  2*NUM_LUTS  flop outputs
- carry_in  in  1  carry chain input
- carry_out  out  1  carry chain output

## Operation
**Config chain**
- On rst: shadow and active are cleared to 0.
- When cen=1: shadow <= {shift_in, shadow[CFG_BITS-1:1]}. Data is streamed LSB first, so the first bit shifted ends at bit 0 after CFG_BITS shifts.
- When set_in=1: active <= shadow, using shadow's value before any same-cycle shift.
- cen and set_in may be asserted together.

**Active config layout**
- T_i = active[i*LUT_CFG +: 2^(S+1)]
- frac_i = active[i*LUT_CFG + 2^(S+1)]
- init_j = active[NUM_LUTS*LUT_CFG + j], for j in 0..2*NUM_LUTS-1
- carry_en = active[CFG_BITS-1]

**LUT i**
- Inputs: a = luts_input[2S*i +: S], b = luts_input[2S*i+S +: S].
- frac_i=1 (split mode): o0 = T_i[{1'b0,a}], o1 = T_i[{1'b1,b}].
- frac_i=0 (fused mode): o0 = o1 = T_i[{b[0],a}].
- lut_output[2i] = o0. lut_output[2i+1] = o1, unless carry_en is set.

**Carry** (when carry_en=1)
- c_0 = carry_in; p_i = o0_i; g_i = a_i[0].
- c_{i+1} = p_i ? c_i : g_i.
- lut_output[2i+1] = p_i ^ c_i.
- carry_out = c_NUM_LUTS.
- When carry_en=0, carry_out = carry_in (bypass).

**Flops** (flop j captures lut_output[j]), priority highest first:
1. rst: 0
2. set_in: init bits taken from the incoming shadow
3. reg_init: init_j
4. reg_we: lut_output[j]
5. otherwise: hold

## Timing
- Reset values: shift_out=0, set_out=0, lut_output_registered=0. lut_output follows an all-zero table (0). With carry_en=0, carry_out=carry_in.
- lut_output and carry_out are combinational from luts_input, carry_in and active config: zero latency.
- A config commit takes effect the cycle after set_in: lut_output reflects the new tables, and the flops hold the new init values.
- set_out is high exactly one cycle after set_in. An N-slice chain therefore commits over N cycles.
- Shifting never disturbs active config or lut_output.
- rst asserted mid-shift discards partial shadow contents. After rst, a full CFG_BITS shifts are required before a commit.
- shift_out changes only on cen cycles and on rst.

## Test plan
- **Reset:** assert rst 2 cycles with arbitrary inputs. Expect all registered outputs = 0, shift_out=0, set_out=0, lut_output=0.
- **Load and commit:**
  - Shift 141 bits making T_0=0xAAAAAAAA (o0=a[0]) with frac_0=1, all other bits 0, then pulse set_in.
  - Expect lut_output[0] to follow luts_input[0] from the next cycle, and set_out to pulse one cycle after set_in.
  - Expect shift_out to reproduce the first bit streamed in.
- **Shadow isolation:** with a config active, shift a different pattern for 100 cycles. lut_output must be unchanged until set_in.
- **Adder:**
  - Configure each LUT as p=a[0]^a[1] with carry_en=1.
  - With a[0] bits=0xF (A), a[1] bits=0x1 (B), carry_in=0: expect sums on lut_output[7,5,3,1] = 0x0, carry_out=1.
  - With carry_in=1: expect sums 0x1.
- **Flop priority:**
  - With init = 8'hA5: set_in with reg_we=1 loads 0xA5.
  - reg_init and reg_we together load 0xA5.
  - reg_we alone captures lut_output.
  - rst with set_in gives 0.
- **Simultaneous cen+set_in:** active takes the pre-shift shadow. A shift_in bit presented in that cycle appears at shadow[CFG_BITS-1] and not in active.
